// File: rtl/iir_cfg_pkg.sv
// Shared types and default sizing for the IIR coefficient loader.
// Default frame is one biquad section: B0, B1, B2, A1, A2.
package iir_cfg_pkg;

  localparam int DEF_COEFF_WIDTH = 20;
  localparam int DEF_COEFF_DEPTH = 5;
  localparam int DEF_HOLDOFF_MAX = 16;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WAIT_GAP = 2'd2,
    ST_CHECK    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SHORT    = 2'd1,
    ERR_LONG     = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_code_e;

endpackage

// File: rtl/iir_coeff_loader.sv
// Collects a coefficient frame into a shadow bank, commits it to the filter in a
// sample gap (or on holdoff timeout), then verifies the filter's readback.
module iir_coeff_loader
  import iir_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int COEFF_DEPTH = DEF_COEFF_DEPTH,
  parameter int HOLDOFF_MAX = DEF_HOLDOFF_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COEFF_WIDTH-1:0] cfg_data,
  input  logic                   cfg_last,
  input  logic                   sample_valid,
  output logic                   coeff_wr_en,
  output logic [COEFF_WIDTH-1:0] coeff_wr_data [COEFF_DEPTH],
  input  logic [COEFF_WIDTH-1:0] coeff_rd_data [COEFF_DEPTH],
  output logic                   busy,
  output logic                   done,
  output logic                   forced,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int IDX_W = (COEFF_DEPTH > 1) ? $clog2(COEFF_DEPTH) : 1;
  localparam int HO_W  = $clog2(HOLDOFF_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COEFF_DEPTH - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_MAX - 1);

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [HO_W-1:0]        holdoff_q;
  logic [COEFF_WIDTH-1:0] shadow_q [COEFF_DEPTH];
  logic                   forced_pend_q;
  logic                   done_q;
  logic                   forced_q;
  logic                   err_q;
  err_code_e              err_code_q;

  logic xfer_s;
  logic wr_en_s;
  logic match_s;

  assign xfer_s = cfg_valid && cfg_ready;

  // Commit strobe: first sample gap in WAIT_GAP, or the last holdoff cycle.
  always_comb begin
    wr_en_s = 1'b0;
    if (state_q == ST_WAIT_GAP) begin
      wr_en_s = !sample_valid || (holdoff_q == HO_LAST);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Bit-exact comparison of the whole readback against the shadow bank.
  always_comb begin
    match_s = 1'b1;
    for (int i = 0; i < COEFF_DEPTH; i++) begin
      if (coeff_rd_data[i] != shadow_q[i]) begin
        match_s = 1'b0;
      end else begin
        match_s = match_s;
      end
    end
  end

  // Loader FSM, shadow bank and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      idx_q         <= '0;
      holdoff_q     <= '0;
      forced_pend_q <= 1'b0;
      done_q        <= 1'b0;
      forced_q      <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      for (int i = 0; i < COEFF_DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      forced_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (xfer_s) begin
            shadow_q[idx_q] <= cfg_data;
            if (cfg_last && (idx_q == IDX_LAST)) begin
              idx_q     <= '0;
              holdoff_q <= '0;
              state_q   <= ST_WAIT_GAP;
            end else if (cfg_last) begin
              idx_q      <= '0;
              err_q      <= 1'b1;
              err_code_q <= ERR_SHORT;
            end else if (idx_q == IDX_LAST) begin
              // Over-length frame: swallow the rest up to its last word.
              idx_q      <= '0;
              err_q      <= 1'b1;
              err_code_q <= ERR_LONG;
              state_q    <= ST_DRAIN;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (xfer_s && cfg_last) begin
            state_q <= ST_LOAD;
          end
        end
        ST_WAIT_GAP: begin
          if (wr_en_s) begin
            forced_pend_q <= sample_valid;
            state_q       <= ST_CHECK;
          end else begin
            holdoff_q <= holdoff_q + HO_W'(1);
          end
        end
        ST_CHECK: begin
          idx_q   <= '0;
          state_q <= ST_LOAD;
          if (match_s) begin
            done_q     <= 1'b1;
            forced_q   <= forced_pend_q;
            err_code_q <= ERR_NONE;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= ERR_MISMATCH;
          end
        end
        default: begin
          state_q <= ST_LOAD;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign cfg_ready     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign busy          = (state_q != ST_LOAD);
  assign coeff_wr_en   = wr_en_s;
  assign coeff_wr_data = shadow_q;
  assign done          = done_q;
  assign forced        = forced_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader with a register-backed filter readback stub.
module tb_iir_coeff_loader;

  localparam int W = 20;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_last = 1'b0;
  logic         sample_valid = 1'b0;
  logic         coeff_wr_en;
  logic [W-1:0] coeff_wr_data [D];
  logic [W-1:0] coeff_rd_data [D];
  logic         busy, done, forced, err;
  logic [1:0]   err_code;
  logic         flip_en = 1'b0;

  iir_coeff_loader #(.COEFF_WIDTH(W), .COEFF_DEPTH(D), .HOLDOFF_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .sample_valid(sample_valid),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_data(coeff_wr_data),
    .coeff_rd_data(coeff_rd_data), .busy(busy), .done(done), .forced(forced),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Filter stand-in: latches the bank on the write strobe, optionally corrupting word 3.
  always @(posedge clk) begin
    if (coeff_wr_en) begin
      for (int i = 0; i < D; i++) begin
        coeff_rd_data[i] <= coeff_wr_data[i] ^ (((i == 3) && flip_en) ? 20'h00001 : 20'h00000);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           wr_total = 0, done_total = 0, err_total = 0;
  int           wr_cyc = 0, done_cyc = 0;
  logic         forced_last = 1'b0, wr_busy = 1'b0;
  logic [W-1:0] cap [D];

  always @(negedge clk) begin
    if (coeff_wr_en) begin
      wr_total <= wr_total + 1;
      wr_cyc   <= cyc;
      wr_busy  <= busy;
      for (int i = 0; i < D; i++) cap[i] <= coeff_wr_data[i];
    end
    if (done) begin
      done_total  <= done_total + 1;
      done_cyc    <= cyc;
      forced_last <= forced;
    end
    if (err) err_total <= err_total + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [W-1:0] base [D];

  function automatic logic [W-1:0] word_of(input int k, input logic [W-1:0] salt);
    logic [W-1:0] hi;
    hi = (k >= D) ? 20'h0F0F0 : 20'h00000;
    return base[k % D] ^ salt ^ hi;
  endfunction

  // Drive one word at posedge+1 and hold it across the next edge.
  task automatic send_word(input logic [W-1:0] d, input logic l);
    chk("cfg_ready", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  typedef struct {
    string        name;
    int           nwords;
    logic         sv;
    logic         flip;
    logic [W-1:0] salt;
    int           exp_wr;
    int           exp_wr_dly;
    int           exp_done;
    int           exp_done_dly;
    logic         exp_forced;
    int           exp_err;
    logic [1:0]   exp_code;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int w0, d0, e0, xfer;
    sample_valid = v.sv;
    flip_en      = v.flip;
    w0 = wr_total; d0 = done_total; e0 = err_total;
    for (int k = 0; k < v.nwords; k++) send_word(word_of(k, v.salt), k == v.nwords - 1);
    xfer = cyc;
    repeat (30) @(posedge clk);
    #1;
    chk({v.name, ".wr_cnt"}, wr_total - w0, v.exp_wr);
    chk({v.name, ".done_cnt"}, done_total - d0, v.exp_done);
    chk({v.name, ".err_cnt"}, err_total - e0, v.exp_err);
    chk({v.name, ".err_code"}, {30'd0, err_code}, {30'd0, v.exp_code});
    chk({v.name, ".cfg_ready_end"}, {31'd0, cfg_ready}, 32'd1);
    if (v.exp_wr > 0) begin
      chk({v.name, ".wr_dly"}, wr_cyc - xfer + 1, v.exp_wr_dly);
      chk({v.name, ".busy_at_wr"}, {31'd0, wr_busy}, 32'd1);
      for (int i = 0; i < D; i++) chk({v.name, ".wr_data"}, cap[i], word_of(i, v.salt));
    end
    if (v.exp_done > 0) begin
      chk({v.name, ".done_dly"}, done_cyc - xfer + 1, v.exp_done_dly);
      chk({v.name, ".forced"}, {31'd0, forced_last}, {31'd0, v.exp_forced});
    end
    if (v.exp_code == 2'd2) begin
      // Drained words must not have landed in the shadow bank.
      for (int i = 0; i < D; i++) chk({v.name, ".shadow_kept"}, coeff_wr_data[i], word_of(i, v.salt));
    end
    sample_valid = 1'b0;
    flip_en      = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    chk({tag, ".wr_en"}, {31'd0, coeff_wr_en}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".forced"}, {31'd0, forced}, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".err_code"}, {30'd0, err_code}, 32'd0);
    for (int i = 0; i < D; i++) chk({tag, ".shadow"}, coeff_wr_data[i], 32'd0);
  endtask

  initial begin
    int w0, d0;
    base[0] = 20'h37061; base[1] = 20'h5907C; base[2] = 20'h37061;
    base[3] = 20'h5907C; base[4] = 20'h2E0C3;
    //           name     n  sv    flip  salt       wr dly done dly forced err code
    vecs[0] = '{"basic", 5, 1'b0, 1'b0, 20'h00000, 1, 1, 1, 3, 1'b0, 0, 2'd0};
    vecs[1] = '{"short", 3, 1'b0, 1'b0, 20'h00000, 0, 0, 0, 0, 1'b0, 1, 2'd1};
    vecs[2] = '{"long",  7, 1'b0, 1'b0, 20'h12345, 0, 0, 0, 0, 1'b0, 1, 2'd2};
    vecs[3] = '{"neg",   5, 1'b0, 1'b0, 20'hFFFFF, 1, 1, 1, 3, 1'b0, 0, 2'd0};
    vecs[4] = '{"hold",  5, 1'b1, 1'b0, 20'h0A5A5, 1, 16, 1, 18, 1'b1, 0, 2'd0};
    vecs[5] = '{"flip",  5, 1'b0, 1'b1, 20'h00000, 1, 1, 0, 0, 1'b0, 1, 2'd3};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("por.ready_after", {31'd0, cfg_ready}, 32'd1);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Reset after two words of a frame: partial frame discarded, no commit.
    w0 = wr_total; d0 = done_total;
    send_word(word_of(0, 20'h00000), 1'b0);
    send_word(word_of(1, 20'h00000), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_mid");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid.no_wr", wr_total - w0, 32'd0);
    run_vec(vecs[0]);

    // Reset while parked in WAIT_GAP with samples streaming.
    w0 = wr_total; d0 = done_total;
    sample_valid = 1'b1;
    for (int k = 0; k < D; k++) send_word(word_of(k, 20'h00F00), k == D - 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_wait");
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("rst_wait.no_wr", wr_total - w0, 32'd0);
    chk("rst_wait.no_done", done_total - d0, 32'd0);
    sample_valid = 1'b0;
    run_vec(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 20, coefficient word width (signed).
REQ-002 SHALL have parameter COEFF_DEPTH, default 5, words per frame (B0,B1,B2,A1,A2 order).
REQ-003 SHALL have parameter HOLDOFF_MAX, default 16, max WAIT_GAP cycles before forced commit.
REQ-004 clk  input  1  clock; all flops rise-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_valid  input  1  config word valid.
REQ-007 cfg_ready  output  1  loader accepts word; transfer when cfg_valid && cfg_ready.
REQ-008 cfg_data  input  COEFF_WIDTH  signed coefficient word.
REQ-009 cfg_last  input  1  marks final word of frame.
REQ-010 sample_valid  input  1  filter sample strobe (same signal as filter valid_in).
REQ-011 coeff_wr_en  output  1  single-cycle coefficient write strobe to filter.
REQ-012 coeff_wr_data  output  COEFF_WIDTH x COEFF_DEPTH  unpacked array, shadow bank to filter coeff_in.
REQ-013 coeff_rd_data  input  COEFF_WIDTH x COEFF_DEPTH  filter coeff_out readback.
REQ-014 busy  output  1  high in any state other than LOAD.
REQ-015 done  output  1  one-cycle pulse, commit verified.
REQ-016 forced  output  1  valid with done; 1 = commit forced by holdoff timeout.
REQ-017 err  output  1  one-cycle error pulse.
REQ-018 err_code  output  2  0 none, 1 short frame, 2 long frame, 3 readback mismatch.

Function
REQ-019 FSM states SHALL be LOAD, DRAIN, WAIT_GAP, CHECK; reset state LOAD, word index idx=0.
REQ-020 LOAD: cfg_ready=1; each transfer writes cfg_data to shadow[idx], idx++.
REQ-021 LOAD, transfer with cfg_last and idx==COEFF_DEPTH-1 -> WAIT_GAP, holdoff counter=0.
REQ-022 LOAD, transfer with cfg_last and idx<COEFF_DEPTH-1 -> err pulse, err_code=1, idx=0, stay LOAD.
REQ-023 LOAD, transfer without cfg_last at idx==COEFF_DEPTH-1 -> err pulse, err_code=2, idx=0, DRAIN.
REQ-024 DRAIN: cfg_ready=1, words discarded, shadow unchanged; transfer with cfg_last -> LOAD.
REQ-025 WAIT_GAP: cfg_ready=0; coeff_wr_en = !sample_valid || (holdoff==HOLDOFF_MAX-1), combinational from state and input; when asserted -> CHECK, else holdoff++.
REQ-026 coeff_wr_en SHALL be high exactly one cycle per accepted frame and never outside WAIT_GAP.
REQ-027 coeff_wr_data SHALL drive shadow registers directly; shadow SHALL not change outside LOAD.
REQ-028 CHECK (one cycle): compare coeff_rd_data to shadow, all words, exact bit match -> LOAD, idx=0.
REQ-029 Match -> done=1 next cycle, err_code=0, forced = commit was timeout-driven; mismatch -> err=1, err_code=3 next cycle.
REQ-030 done, err, forced SHALL be registered pulses; err_code SHALL hold last value until next done or err.
REQ-031 Latency: last word at edge N, sample_valid=0 at N+1 -> coeff_wr_en in cycle N+1, CHECK N+2, done N+3.
REQ-032 Short-frame and long-frame errors SHALL never assert coeff_wr_en; filter keeps prior coefficients.
REQ-033 No arithmetic on coefficients; words pass bit-exact, signedness preserved.

Reset
REQ-034 rst_n low SHALL force: state LOAD, idx 0, holdoff 0, shadow all 0, cfg_ready 1 after release, coeff_wr_en 0, busy 0, done 0, forced 0, err 0, err_code 0.
REQ-035 Reset mid-frame or mid-WAIT_GAP SHALL discard partial frame with no coeff_wr_en.

Structure
REQ-036 Package iir_cfg_pkg SHALL hold state enum, err_code enum, default COEFF_WIDTH/COEFF_DEPTH/HOLDOFF_MAX.
REQ-037 Single module; no sub-module; FSM, shadow bank, comparator inline.

Verification
REQ-038 Frame 0x37061,0x5907C,0x37061,0x5907C,0x2E0C3, last on 5th, sample_valid=0 -> coeff_wr_en 1 cycle, coeff_wr_data equals frame, done at N+3, forced=0, err_code=0.
REQ-039 3 words, cfg_last on 3rd -> err pulse, err_code=1, no coeff_wr_en, cfg_ready stays 1.
REQ-040 7 words, cfg_last on 7th -> err_code=2 after 5th, words 6-7 dropped, next valid 5-word frame gives done.
REQ-041 sample_valid held 1 -> coeff_wr_en in 16th WAIT_GAP cycle, done with forced=1.
REQ-042 Readback stub flips bit 0 of word 3 -> err pulse, err_code=3, no done.
REQ-043 rst_n pulsed after 2 words -> all outputs at reset values, next full frame commits with done.
